alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
- Parametrised, synthesizable in-order result checker for the ALU.
- Snoops the command interface (start/op/A/B) and computes the expected result for each accepted command.
- Queues expected results in a DEPTH-entry FIFO, then compares each done/result pair against the queue head.
- Tracks pass/fail/protocol errors in hardware, so multiple outstanding (pipelined) operations and any operand width are supported. Sits beside the DUT in the bench top, also usable as an on-chip monitor.

Parameters:
- WIDTH, 8, operand width of A and B.
- DEPTH, 4, expected-result FIFO entries (power of 2, >=2).
- CNT_W, 16, width of pass/fail counters.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  command valid, sampled each rising clk
- op  input  3  opcode: no_op=000, add_op=001, and_op=010, xor_op=011, mul_op=100, rst_op=111; others illegal
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- done  input  1  DUT result valid, one-cycle pulse per result
- result  input  2*WIDTH  DUT result
- mismatch  output  1  one-cycle pulse, compare failed
- exp_result  output  2*WIDTH  expected value of last compare
- act_result  output  2*WIDTH  actual value of last compare
- last_op  output  3  opcode of last compare
- pass_count  output  CNT_W  compares that matched, saturating
- fail_count  output  CNT_W  compares that mismatched, saturating
- outstanding  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky: push attempted while full
- unexpected_done  output  1  sticky: done with FIFO empty
- illegal_op  output  1  sticky: start with undefined opcode

Behaviour:
- Reset (asynchronous, any time, including mid-operation): all outputs 0; FIFO empty; pointers 0; all pending expectations discarded.
- Accept: start=1 and op in {add, and, xor, mul} -> push expected value at that rising edge.
- Expected value arithmetic, zero-extended to 2*WIDTH:
  - add: A+B, WIDTH+1 bits, carry kept.
  - and: A&B.
  - xor: A^B.
  - mul: A*B, full 2*WIDTH bits.
- Each entry also stores op.
- start with op=no_op: ignored, no push.
- start with op=rst_op: flushes FIFO (occupancy 0); counters and sticky flags unchanged.
- start with op in {101, 110}: no push; sets illegal_op.
- Handshake: one push per cycle in which start=1. The driver holds start for exactly one cycle per command; a multi-cycle start pushes once per cycle.
- Compare: done=1 with FIFO non-empty -> pop head and compare against result. Results are registered, so outputs update on the next rising edge (latency 1 cycle from done):
  - exp_result, act_result and last_op load the compared values.
  - On mismatch: mismatch=1 for exactly one cycle and fail_count increments.
  - On match: pass_count increments.
- done with FIFO empty: no pop, no count change; sets unexpected_done. This includes the case of a push in the same cycle, because a push is not visible to a compare in the same cycle.
- Simultaneous push and pop when FIFO is non-empty: both happen, occupancy unchanged.
- Full FIFO (occupancy=DEPTH) with push and no pop: push dropped; set overflow.
- Full FIFO with push and pop in the same cycle: both allowed.
- rst_op in the same cycle as done: the compare uses the current head, then the FIFO empties.
- Pointers wrap modulo DEPTH. Occupancy ranges 0..DEPTH.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Sticky flags clear only on reset.

Test Plan:
- Single add, WIDTH=8: start, add, A=8'hFF, B=8'h01; 3 cycles later done with result=16'h0100 -> one cycle after done, mismatch=0, pass_count=1, exp_result=16'h0100, outstanding back to 0.
- Mul mismatch: A=8'hFF, B=8'hFF; done with result=16'hFE00 -> mismatch pulses one cycle, exp_result=16'hFE01, act_result=16'hFE00, fail_count=1.
- Pipelined burst: and(8'hF0,8'h3C), xor(8'hF0,8'h3C), add(8'h10,8'h20), mul(8'h03,8'h04) on 4 consecutive cycles:
  - outstanding reaches 4.
  - Results 0030, 00CC, 0030, 000C return in order -> pass_count=4, no error flags.
- Overflow/wrap: 5 pushes with no done -> overflow=1, outstanding=4. Then 4 correct dones -> pass_count=4 (the 5th command is lost). Further 6 push/compare pairs wrap the pointers with no mismatch.
- Protocol errors:
  - done with empty FIFO -> unexpected_done=1, counts unchanged.
  - start with op=3'b101 -> illegal_op=1, outstanding unchanged.
- Flush and reset:
  - 3 pushes then start with rst_op -> outstanding=0; a subsequent done sets unexpected_done.
  - reset asserted mid-burst (asynchronously, between edges) -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_checker
// Purpose  : In-order scoreboard for the ALU. Snoops the command interface,
//            computes the expected result of every accepted command, queues
//            it in a DEPTH-entry FIFO and compares each done/result pair with
//            the FIFO head. Keeps pass/fail counters and sticky protocol
//            error flags.
// Ports    : clk, reset (async, active high)
//            start/op/A/B       - command snoop
//            done/result        - DUT result snoop
//            mismatch           - one-cycle pulse on a failed compare
//            exp_result/act_result/last_op - values of the last compare
//            pass_count/fail_count         - saturating compare counters
//            outstanding        - FIFO occupancy (0..DEPTH)
//            overflow/unexpected_done/illegal_op - sticky protocol errors
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_checker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           A,
    input  logic [WIDTH-1:0]           B,
    input  logic                       done,
    input  logic [2*WIDTH-1:0]         result,
    output logic                       mismatch,
    output logic [2*WIDTH-1:0]         exp_result,
    output logic [2*WIDTH-1:0]         act_result,
    output logic [2:0]                 last_op,
    output logic [CNT_W-1:0]           pass_count,
    output logic [CNT_W-1:0]           fail_count,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       overflow,
    output logic                       unexpected_done,
    output logic                       illegal_op
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int RES_W = 2 * WIDTH;

    localparam logic [2:0] c_op_add = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_xor = 3'b011;
    localparam logic [2:0] c_op_mul = 3'b100;
    localparam logic [2:0] c_op_rst = 3'b111;
    localparam logic [2:0] c_op_r5  = 3'b101;
    localparam logic [2:0] c_op_r6  = 3'b110;

    localparam logic [OCC_W-1:0] c_full = OCC_W'(DEPTH);

    logic [RES_W-1:0] r_exp_mem [DEPTH];
    logic [2:0]       r_op_mem  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    logic [RES_W-1:0] w_a_ext;
    logic [RES_W-1:0] w_b_ext;
    logic [RES_W-1:0] w_exp;
    logic             w_legal;
    logic             w_flush;
    logic             w_illegal;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [RES_W-1:0] w_head_exp;
    logic [2:0]       w_head_op;

    // Operands are zero-extended to the result width so the add keeps its
    // carry and the multiply produces the full 2*WIDTH product.
    assign w_a_ext = {{WIDTH{1'b0}}, A};
    assign w_b_ext = {{WIDTH{1'b0}}, B};

    always_comb begin
        w_exp = '0;
        unique case (op)
            c_op_add: w_exp = w_a_ext + w_b_ext;
            c_op_and: w_exp = w_a_ext & w_b_ext;
            c_op_xor: w_exp = w_a_ext ^ w_b_ext;
            c_op_mul: w_exp = w_a_ext * w_b_ext;
            default:  w_exp = '0;
        endcase
    end

    assign w_legal   = start && ((op == c_op_add) || (op == c_op_and) ||
                                 (op == c_op_xor) || (op == c_op_mul));
    assign w_flush   = start && (op == c_op_rst);
    assign w_illegal = start && ((op == c_op_r5) || (op == c_op_r6));

    assign w_empty   = (outstanding == '0);
    assign w_full    = (outstanding == c_full);
    // A push only becomes visible to compares from the next cycle, so the
    // pop decision looks at the registered occupancy alone.
    assign w_pop     = done && !w_empty;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push    = w_legal && (!w_full || w_pop);

    assign w_head_exp = r_exp_mem[r_rd_ptr];
    assign w_head_op  = r_op_mem[r_rd_ptr];

    // Storage array carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_exp_mem[r_wr_ptr] <= w_exp;
            r_op_mem[r_wr_ptr]  <= op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            outstanding     <= '0;
            mismatch        <= 1'b0;
            exp_result      <= '0;
            act_result      <= '0;
            last_op         <= '0;
            pass_count      <= '0;
            fail_count      <= '0;
            overflow        <= 1'b0;
            unexpected_done <= 1'b0;
            illegal_op      <= 1'b0;
        end else begin
            mismatch <= 1'b0;

            if (w_pop) begin
                exp_result <= w_head_exp;
                act_result <= result;
                last_op    <= w_head_op;
                if (w_head_exp != result) begin
                    mismatch <= 1'b1;
                    if (fail_count != '1) begin
                        fail_count <= fail_count + CNT_W'(1);
                    end
                end else if (pass_count != '1) begin
                    pass_count <= pass_count + CNT_W'(1);
                end
            end

            // rst_op never coincides with a push (different opcode), and a
            // compare in the same cycle has already consumed the head above.
            if (w_flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                outstanding <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    outstanding <= outstanding + OCC_W'(1);
                end else if (w_pop && !w_push) begin
                    outstanding <= outstanding - OCC_W'(1);
                end
            end

            if (w_legal && w_full && !w_pop) begin
                overflow <= 1'b1;
            end
            if (done && w_empty) begin
                unexpected_done <= 1'b1;
            end
            if (w_illegal) begin
                illegal_op <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_checker
// Purpose  : Self-checking bench for alu_result_checker. A queue-based model
//            of the expected-result scoreboard is compared against every DUT
//            output on each falling clock edge; directed scenarios add
//            hand-computed literal checks. Counters use a narrow width so
//            saturation can be reached quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_checker;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] XOR = 3'b011;
    localparam logic [2:0] MUL = 3'b100;
    localparam logic [2:0] RST = 3'b111;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic [2:0]             op = '0;
    logic [WIDTH-1:0]       A = '0;
    logic [WIDTH-1:0]       B = '0;
    logic                   done = 1'b0;
    logic [2*WIDTH-1:0]     result = '0;
    logic                   mismatch;
    logic [2*WIDTH-1:0]     exp_result;
    logic [2*WIDTH-1:0]     act_result;
    logic [2:0]             last_op;
    logic [CNT_W-1:0]       pass_count;
    logic [CNT_W-1:0]       fail_count;
    logic [$clog2(DEPTH):0] outstanding;
    logic                   overflow;
    logic                   unexpected_done;
    logic                   illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .done(done), .result(result), .mismatch(mismatch),
        .exp_result(exp_result), .act_result(act_result), .last_op(last_op),
        .pass_count(pass_count), .fail_count(fail_count),
        .outstanding(outstanding), .overflow(overflow),
        .unexpected_done(unexpected_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] e;
        logic [2:0]  o;
    } ent_t;

    ent_t        m_q[$];
    logic        m_mis = 0;
    logic [15:0] m_exp = 0;
    logic [15:0] m_act = 0;
    logic [2:0]  m_lop = 0;
    int          m_pass = 0;
    int          m_fail = 0;
    logic        m_ovf = 0;
    logic        m_unx = 0;
    logic        m_ill = 0;

    function automatic logic [15:0] model_exp(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        case (o)
            ADD:     return 16'(ia + ib);
            AND:     return 16'(ia & ib);
            XOR:     return 16'(ia ^ ib);
            MUL:     return 16'(ia * ib);
            default: return 16'h0;
        endcase
    endfunction

    // Inputs change only just after a rising edge, so the values seen here
    // are exactly the ones the next rising edge will sample.
    always @(negedge clk) begin
        int   sz;
        bit   popped;
        ent_t h;
        ent_t ne;
        if (reset) begin
            m_q.delete();
            m_mis = 0; m_exp = 0; m_act = 0; m_lop = 0;
            m_pass = 0; m_fail = 0; m_ovf = 0; m_unx = 0; m_ill = 0;
        end
        chk("mismatch",        32'(mismatch),        32'(m_mis));
        chk("exp_result",      32'(exp_result),      32'(m_exp));
        chk("act_result",      32'(act_result),      32'(m_act));
        chk("last_op",         32'(last_op),         32'(m_lop));
        chk("pass_count",      32'(pass_count),      32'(m_pass));
        chk("fail_count",      32'(fail_count),      32'(m_fail));
        chk("outstanding",     32'(outstanding),     32'(m_q.size()));
        chk("overflow",        32'(overflow),        32'(m_ovf));
        chk("unexpected_done", 32'(unexpected_done), 32'(m_unx));
        chk("illegal_op",      32'(illegal_op),      32'(m_ill));
        if (!reset) begin
            sz     = m_q.size();
            popped = 0;
            m_mis  = 0;
            if (done) begin
                if (sz > 0) begin
                    h      = m_q.pop_front();
                    popped = 1;
                    m_exp  = h.e;
                    m_act  = result;
                    m_lop  = h.o;
                    if (h.e != result) begin
                        m_mis = 1;
                        if (m_fail < MAXC) m_fail++;
                    end else if (m_pass < MAXC) begin
                        m_pass++;
                    end
                end else begin
                    m_unx = 1;
                end
            end
            if (start) begin
                case (op)
                    ADD, AND, XOR, MUL: begin
                        if (sz < DEPTH || popped) begin
                            ne.e = model_exp(op, A, B);
                            ne.o = op;
                            m_q.push_back(ne);
                        end else begin
                            m_ovf = 1;
                        end
                    end
                    RST:            m_q.delete();
                    3'b101, 3'b110: m_ill = 1;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic s, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic d, input logic [15:0] r);
        start = s; op = o; A = a; B = b; done = d; result = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        done  = 1'b0;
    endtask

    task automatic push(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        drive(1'b1, o, a, b, 1'b0, 16'h0);
    endtask

    task automatic cmp(input logic [15:0] r);
        drive(1'b0, NOP, 8'h0, 8'h0, 1'b1, r);
    endtask

    task automatic idle();
        drive(1'b0, NOP, 8'h0, 8'h0, 1'b0, 16'h0);
    endtask

    // Asserts reset between edges and checks outputs clear without a clock.
    task automatic async_reset();
        start = 1'b0; done = 1'b0; op = NOP; A = '0; B = '0; result = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst mismatch",    32'(mismatch),        32'h0);
        chk("arst exp_result",  32'(exp_result),      32'h0);
        chk("arst act_result",  32'(act_result),      32'h0);
        chk("arst pass_count",  32'(pass_count),      32'h0);
        chk("arst fail_count",  32'(fail_count),      32'h0);
        chk("arst outstanding", 32'(outstanding),     32'h0);
        chk("arst overflow",    32'(overflow),        32'h0);
        chk("arst unexpected",  32'(unexpected_done), 32'h0);
        chk("arst illegal",     32'(illegal_op),      32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset pass_count",  32'(pass_count),  32'h0);
        chk("reset outstanding", 32'(outstanding), 32'h0);
        chk("reset mismatch",    32'(mismatch),    32'h0);

        // Single add with carry, result three cycles later
        push(ADD, 8'hFF, 8'h01);
        chk("add outstanding", 32'(outstanding), 32'h1);
        idle();
        idle();
        cmp(16'h0100);
        chk("add mismatch",    32'(mismatch),    32'h0);
        chk("add pass_count",  32'(pass_count),  32'h1);
        chk("add exp_result",  32'(exp_result),  32'h0100);
        chk("add outstanding", 32'(outstanding), 32'h0);

        // Multiply mismatch
        push(MUL, 8'hFF, 8'hFF);
        idle();
        cmp(16'hFE00);
        chk("mul mismatch",   32'(mismatch),   32'h1);
        chk("mul exp_result", 32'(exp_result), 32'hFE01);
        chk("mul act_result", 32'(act_result), 32'hFE00);
        chk("mul fail_count", 32'(fail_count), 32'h1);
        idle();
        chk("mul pulse ends", 32'(mismatch),   32'h0);

        // Pipelined burst
        async_reset();
        push(AND, 8'hF0, 8'h3C);
        push(XOR, 8'hF0, 8'h3C);
        push(ADD, 8'h10, 8'h20);
        push(MUL, 8'h03, 8'h04);
        chk("burst outstanding", 32'(outstanding), 32'h4);
        cmp(16'h0030);
        cmp(16'h00CC);
        cmp(16'h0030);
        cmp(16'h000C);
        chk("burst pass_count", 32'(pass_count), 32'h4);
        chk("burst last_op",    32'(last_op),    32'(MUL));
        chk("burst flags",      32'({overflow, unexpected_done, illegal_op}), 32'h0);

        // Overflow, wrap, full push+pop, saturation
        async_reset();
        for (int i = 1; i <= 5; i++) push(ADD, 8'(i), 8'(i));
        chk("ovf overflow",    32'(overflow),    32'h1);
        chk("ovf outstanding", 32'(outstanding), 32'h4);
        cmp(16'h0002);
        cmp(16'h0004);
        cmp(16'h0006);
        cmp(16'h0008);
        chk("ovf pass_count",  32'(pass_count),  32'h4);
        chk("ovf outstanding0", 32'(outstanding), 32'h0);
        for (int i = 16; i < 22; i++) begin
            push(ADD, 8'(i), 8'(i));
            cmp(16'(2 * i));
        end
        chk("wrap pass_count", 32'(pass_count), 32'd10);
        chk("wrap fail_count", 32'(fail_count), 32'h0);
        push(ADD, 8'd1, 8'd2);
        push(ADD, 8'd3, 8'd4);
        push(ADD, 8'd5, 8'd6);
        push(ADD, 8'd7, 8'd8);
        drive(1'b1, ADD, 8'd9, 8'd9, 1'b1, 16'h0003);
        chk("fullpp outstanding", 32'(outstanding), 32'h4);
        chk("fullpp pass_count",  32'(pass_count),  32'd11);
        cmp(16'h0007);
        cmp(16'h000B);
        cmp(16'h000F);
        cmp(16'h0012);
        chk("sat reach", 32'(pass_count), 32'd15);
        for (int i = 0; i < 2; i++) begin
            push(XOR, 8'h55, 8'hAA);
            cmp(16'h00FF);
        end
        chk("sat hold", 32'(pass_count), 32'd15);

        // Protocol errors
        async_reset();
        cmp(16'h0055);
        chk("udone flag",       32'(unexpected_done), 32'h1);
        chk("udone pass_count", 32'(pass_count),      32'h0);
        chk("udone fail_count", 32'(fail_count),      32'h0);
        push(3'b101, 8'h01, 8'h01);
        chk("illegal flag",        32'(illegal_op),  32'h1);
        chk("illegal outstanding", 32'(outstanding), 32'h0);
        push(NOP, 8'h01, 8'h01);
        push(3'b110, 8'h02, 8'h02);
        chk("nop outstanding", 32'(outstanding), 32'h0);
        drive(1'b1, ADD, 8'd1, 8'd2, 1'b1, 16'h0003);
        chk("samecyc outstanding", 32'(outstanding), 32'h1);
        chk("samecyc pass_count",  32'(pass_count),  32'h0);
        cmp(16'h0003);
        chk("samecyc later pass", 32'(pass_count), 32'h1);

        // Flush
        async_reset();
        push(ADD, 8'd1, 8'd1);
        push(ADD, 8'd2, 8'd2);
        drive(1'b1, RST, 8'd0, 8'd0, 1'b1, 16'h0002);
        chk("flushcmp pass_count",  32'(pass_count),  32'h1);
        chk("flushcmp outstanding", 32'(outstanding), 32'h0);
        push(AND, 8'hFF, 8'h0F);
        push(XOR, 8'hFF, 8'h0F);
        push(MUL, 8'h10, 8'h10);
        chk("flush pre", 32'(outstanding), 32'h3);
        push(RST, 8'h0, 8'h0);
        chk("flush outstanding", 32'(outstanding), 32'h0);
        cmp(16'h000F);
        chk("flush udone", 32'(unexpected_done), 32'h1);
        chk("flush pass",  32'(pass_count),      32'h1);

        // Reset mid-burst
        async_reset();
        push(MUL, 8'h02, 8'h03);
        push(MUL, 8'h04, 8'h05);
        push(MUL, 8'h06, 8'h07);
        async_reset();
        push(ADD, 8'h80, 8'h80);
        cmp(16'h0100);
        chk("post-rst pass", 32'(pass_count), 32'h1);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
